iexec_issue_buf: RTL and testbench

- Two-entry skid buffer between the fetch response and the EXU instruction-execute request.
- Registers each accepted 32-bit instruction with its PC.
- Pre-extracts the RV32I fields (rd, rs1, funct3, sign-extended I-immediate) so the per-class EXU handlers take them straight from flops.
- Supports full throughput, a registered ready toward fetch, and a synchronous flush for branch/jump redirect.

---
 rtl/iexec_issue_buf_pkg.sv | 25 ++
 rtl/iexec_field_dec.sv | 19 +
 rtl/iexec_issue_buf.sv | 111 +++++++++++
 tb/tb_iexec_issue_buf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iexec_issue_buf_pkg.sv
// Shared types and RV32I field positions for the instruction-execute issue path.
// The entry struct is also what the EXU class handlers consume.
package iexec_issue_buf_pkg;

  localparam int unsigned IssXlen = 32;
  localparam int unsigned IssIlen = 32;

  localparam int unsigned RegIdxW  = 5;
  localparam int unsigned Funct3W  = 3;
  localparam int unsigned ImmW     = 12;
  localparam int unsigned RdLsb    = 7;
  localparam int unsigned Funct3Lsb = 12;
  localparam int unsigned Rs1Lsb   = 15;
  localparam int unsigned ImmLsb   = 20;

  typedef struct packed {
    logic [IssIlen-1:0] inst;
    logic [IssXlen-1:0] pc;
    logic [RegIdxW-1:0] rd;
    logic [RegIdxW-1:0] rs1;
    logic [Funct3W-1:0] funct3;
    logic [IssXlen-1:0] imm;
  } iexec_entry_t;

endpackage

// File: rtl/iexec_field_dec.sv
// Combinational RV32I field extraction: rd, rs1, funct3 and sign-extended I-immediate.
module iexec_field_dec
  import iexec_issue_buf_pkg::*;
(
  input  logic [IssIlen-1:0] inst_i,
  output logic [RegIdxW-1:0] rd_o,
  output logic [RegIdxW-1:0] rs1_o,
  output logic [Funct3W-1:0] funct3_o,
  output logic [IssXlen-1:0] imm_o
);

  always_comb begin
    rd_o     = inst_i[RdLsb +: RegIdxW];
    rs1_o    = inst_i[Rs1Lsb +: RegIdxW];
    funct3_o = inst_i[Funct3Lsb +: Funct3W];
    imm_o    = {{(IssXlen - ImmW){inst_i[ImmLsb + ImmW - 1]}}, inst_i[ImmLsb +: ImmW]};
  end

endmodule

// File: rtl/iexec_issue_buf.sv
// Two-entry skid buffer from fetch response to EXU request, storing pre-decoded fields.
// Ready toward fetch comes straight from the skid valid flop.
module iexec_issue_buf
  import iexec_issue_buf_pkg::*;
#(
  parameter int unsigned XLEN = IssXlen,
  parameter int unsigned ILEN = IssIlen
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ifetch_rsp_vld,
  output logic            ifetch_rsp_rdy,
  input  logic [ILEN-1:0] ifetch_rsp_inst,
  input  logic [XLEN-1:0] ifetch_rsp_pc,
  output logic            iexec_req_vld,
  input  logic            iexec_req_rdy,
  output logic [ILEN-1:0] iexec_req_inst,
  output logic [XLEN-1:0] iexec_req_pc,
  output logic [4:0]      iexec_req_rd,
  output logic [4:0]      iexec_req_rs1,
  output logic [2:0]      iexec_req_funct3,
  output logic [XLEN-1:0] iexec_req_imm,
  output logic [1:0]      occupancy
);

  iexec_entry_t in_entry;
  iexec_entry_t main_q, main_d;
  iexec_entry_t skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [1:0]   occ_q, occ_d;
  logic         in_hsk, out_hsk;

  iexec_field_dec u_field_dec (
    .inst_i   (ifetch_rsp_inst),
    .rd_o     (in_entry.rd),
    .rs1_o    (in_entry.rs1),
    .funct3_o (in_entry.funct3),
    .imm_o    (in_entry.imm)
  );

  always_comb begin
    in_entry.inst = ifetch_rsp_inst;
    in_entry.pc   = ifetch_rsp_pc;
  end

  always_comb begin
    ifetch_rsp_rdy = !skid_vld_q;
    iexec_req_vld  = main_vld_q;
    in_hsk         = ifetch_rsp_vld & !skid_vld_q;
    out_hsk        = main_vld_q & iexec_req_rdy;
  end

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // A concurrent out_hsk is still consumed by the EXU; the in_hsk is dropped.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (in_hsk) begin
        main_d     = in_entry;
        main_vld_d = 1'b1;
      end
    end else if (out_hsk) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_hsk) begin
        main_d = in_entry;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_hsk) begin
      skid_d     = in_entry;
      skid_vld_d = 1'b1;
    end
    occ_d = {1'b0, main_vld_d} + {1'b0, skid_vld_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      occ_q      <= occ_d;
    end
  end

  always_comb begin
    iexec_req_inst   = main_q.inst;
    iexec_req_pc     = main_q.pc;
    iexec_req_rd     = main_q.rd;
    iexec_req_rs1    = main_q.rs1;
    iexec_req_funct3 = main_q.funct3;
    iexec_req_imm    = main_q.imm;
    occupancy        = occ_q;
  end

endmodule

// File: tb/tb_iexec_issue_buf.sv
// Scoreboard bench for iexec_issue_buf: directed scenarios followed by random vld/rdy traffic.
module tb_iexec_issue_buf;
  import iexec_issue_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ifetch_rsp_vld;
  logic        ifetch_rsp_rdy;
  logic [31:0] ifetch_rsp_inst;
  logic [31:0] ifetch_rsp_pc;
  logic        iexec_req_vld;
  logic        iexec_req_rdy;
  logic [31:0] iexec_req_inst;
  logic [31:0] iexec_req_pc;
  logic [4:0]  iexec_req_rd;
  logic [4:0]  iexec_req_rs1;
  logic [2:0]  iexec_req_funct3;
  logic [31:0] iexec_req_imm;
  logic [1:0]  occupancy;

  iexec_issue_buf dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .ifetch_rsp_vld   (ifetch_rsp_vld),
    .ifetch_rsp_rdy   (ifetch_rsp_rdy),
    .ifetch_rsp_inst  (ifetch_rsp_inst),
    .ifetch_rsp_pc    (ifetch_rsp_pc),
    .iexec_req_vld    (iexec_req_vld),
    .iexec_req_rdy    (iexec_req_rdy),
    .iexec_req_inst   (iexec_req_inst),
    .iexec_req_pc     (iexec_req_pc),
    .iexec_req_rd     (iexec_req_rd),
    .iexec_req_rs1    (iexec_req_rs1),
    .iexec_req_funct3 (iexec_req_funct3),
    .iexec_req_imm    (iexec_req_imm),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  int unsigned  n_out  = 0;
  bit           mon_en = 1'b0;
  iexec_entry_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic iexec_entry_t model(input logic [31:0] inst, input logic [31:0] pc);
    iexec_entry_t e;
    e.inst   = inst;
    e.pc     = pc;
    e.rd     = inst[11:7];
    e.rs1    = inst[19:15];
    e.funct3 = inst[14:12];
    e.imm    = {{20{inst[31]}}, inst[31:20]};
    return e;
  endfunction

  // Monitor: compare every out_hsk against the queue, then record accepted inputs.
  always @(negedge clk) begin
    if (mon_en) begin
      iexec_entry_t e;
      chk("occupancy_vs_model", {30'd0, occupancy}, exp_q.size());
      if (rst_n && iexec_req_vld && iexec_req_rdy) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", iexec_req_inst, 32'hdeadbeef);
        end else begin
          e = exp_q.pop_front();
          chk("out_inst", iexec_req_inst, e.inst);
          chk("out_pc", iexec_req_pc, e.pc);
          chk("out_rd", {27'd0, iexec_req_rd}, {27'd0, e.rd});
          chk("out_rs1", {27'd0, iexec_req_rs1}, {27'd0, e.rs1});
          chk("out_funct3", {29'd0, iexec_req_funct3}, {29'd0, e.funct3});
          chk("out_imm", iexec_req_imm, e.imm);
        end
      end
      if (!rst_n || flush) exp_q.delete();
      else if (ifetch_rsp_vld && ifetch_rsp_rdy) exp_q.push_back(model(ifetch_rsp_inst, ifetch_rsp_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    ifetch_rsp_vld  = 1'b1;
    ifetch_rsp_inst = inst;
    ifetch_rsp_pc   = pc;
    step();
    ifetch_rsp_vld  = 1'b0;
  endtask

  localparam logic [31:0] InstA = 32'hFFF00113;  // addi x2,x0,-1
  localparam logic [31:0] InstB = 32'h00A18193;  // addi x3,x3,10
  localparam logic [31:0] InstC = 32'h00200213;  // addi x4,x0,2

  initial begin
    logic        r0;
    logic        v0;
    int unsigned base;
    rst_n = 1'b0; flush = 1'b0; ifetch_rsp_vld = 1'b0;
    ifetch_rsp_inst = '0; ifetch_rsp_pc = '0; iexec_req_rdy = 1'b0;
    repeat (3) step();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    chk("reset_vld", {31'd0, iexec_req_vld}, 32'd0);
    chk("reset_rdy", {31'd0, ifetch_rsp_rdy}, 32'd1);
    chk("reset_occ", {30'd0, occupancy}, 32'd0);
    chk("reset_inst", iexec_req_inst, 32'd0);
    chk("reset_imm", iexec_req_imm, 32'd0);

    // Single addi, latency 1.
    iexec_req_rdy = 1'b1;
    push(32'h00500093, 32'h80000000);
    chk("addi_vld", {31'd0, iexec_req_vld}, 32'd1);
    chk("addi_rd", {27'd0, iexec_req_rd}, 32'd1);
    chk("addi_rs1", {27'd0, iexec_req_rs1}, 32'd0);
    chk("addi_funct3", {29'd0, iexec_req_funct3}, 32'd0);
    chk("addi_imm", iexec_req_imm, 32'h00000005);
    chk("addi_pc", iexec_req_pc, 32'h80000000);
    step();
    chk("addi_drained", {31'd0, iexec_req_vld}, 32'd0);

    // Streaming at full rate.
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      ifetch_rsp_vld  = 1'b1;
      ifetch_rsp_inst = {12'(i * 291), 5'(i), 3'(i), 5'(i + 1), 7'h13};
      ifetch_rsp_pc   = 32'h1000 + 32'(i * 4);
      step();
      chk("stream_occ_le1", {31'd0, occupancy <= 2'd1}, 32'd1);
      chk("stream_rdy", {31'd0, ifetch_rsp_rdy}, 32'd1);
    end
    ifetch_rsp_vld = 1'b0;
    step();
    chk("stream_count", n_out - base, 32'd8);

    // Backpressure fills the skid entry.
    iexec_req_rdy = 1'b0;
    push(InstA, 32'h2000);
    push(InstB, 32'h2004);
    chk("bp_occ", {30'd0, occupancy}, 32'd2);
    chk("bp_rdy", {31'd0, ifetch_rsp_rdy}, 32'd0);
    chk("bp_hold_inst", iexec_req_inst, InstA);
    chk("bp_hold_imm", iexec_req_imm, 32'hFFFFFFFF);
    step();
    chk("bp_stable_inst", iexec_req_inst, InstA);
    iexec_req_rdy = 1'b1;
    step();
    chk("bp_b_next", iexec_req_inst, InstB);
    chk("bp_rdy_back", {31'd0, ifetch_rsp_rdy}, 32'd1);
    step();
    chk("bp_empty", {31'd0, iexec_req_vld}, 32'd0);

    // Flush while full; C is offered but cannot be accepted.
    iexec_req_rdy = 1'b0;
    push(InstA, 32'h3000);
    push(InstB, 32'h3004);
    flush = 1'b1;
    push(InstC, 32'h3008);
    flush = 1'b0;
    chk("flush2_vld", {31'd0, iexec_req_vld}, 32'd0);
    chk("flush2_occ", {30'd0, occupancy}, 32'd0);
    chk("flush2_rdy", {31'd0, ifetch_rsp_rdy}, 32'd1);

    // Flush with one entry and a real in_hsk of C: C is dropped.
    push(InstA, 32'h3100);
    flush = 1'b1;
    push(InstC, 32'h3104);
    flush = 1'b0;
    iexec_req_rdy = 1'b1;
    chk("flush1_vld", {31'd0, iexec_req_vld}, 32'd0);
    step();
    step();
    chk("flush1_no_c", {31'd0, iexec_req_vld}, 32'd0);

    // Reset while full.
    iexec_req_rdy = 1'b0;
    push(InstA, 32'h4000);
    push(InstB, 32'h4004);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_vld", {31'd0, iexec_req_vld}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_rdy", {31'd0, ifetch_rsp_rdy}, 32'd1);
    chk("rst_inst", iexec_req_inst, 32'd0);
    chk("rst_pc", iexec_req_pc, 32'd0);
    chk("rst_fields", {17'd0, iexec_req_rd, iexec_req_rs1, iexec_req_funct3}, 32'd0);
    chk("rst_imm", iexec_req_imm, 32'd0);

    // Random traffic; EXU ready toggles mid-cycle to expose any combinational path.
    for (int c = 0; c < 10000; c++) begin
      step();
      r0 = ifetch_rsp_rdy;
      v0 = iexec_req_vld;
      ifetch_rsp_vld  = 1'($urandom_range(0, 1));
      ifetch_rsp_inst = $urandom;
      ifetch_rsp_pc   = $urandom;
      flush           = ($urandom_range(0, 31) == 0);
      iexec_req_rdy   = 1'($urandom_range(0, 1));
      #2;
      iexec_req_rdy   = ~iexec_req_rdy;
      #1;
      chk("rdy_no_comb", {31'd0, ifetch_rsp_rdy}, {31'd0, r0});
      chk("vld_no_comb", {31'd0, iexec_req_vld}, {31'd0, v0});
    end
    ifetch_rsp_vld = 1'b0;
    flush          = 1'b0;
    iexec_req_rdy  = 1'b1;
    repeat (4) step();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
